serial_adder: RTL and testbench

- Parametrised, bit-serial successor to the single-bit half adder.
- Adds two WIDTH-bit operands one bit per clock, LSB first, through a single-bit full-add cell and a registered carry flip-flop.
- Uses a start/busy/done handshake, so the sum is valid only after a fixed, known latency.
- Intended as the arithmetic core for later multi-cycle datapath experiments (accumulator, serial multiplier).

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one bit per clock.
// A single full-add cell feeds a sum shift register; the carry is held in a
// flip-flop between bits. start/busy/done handshake, result valid with done.
// Optional macro SERIAL_ADDER_CIN_EN adds a cin port loaded into the carry
// flip-flop on the accepted start edge (for chaining multi-word adds).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_d;
  logic             carry_d;
  logic             busy_d;
  logic             done_d;
  logic             sum_bit;
  logic             carry_bit;
  logic             cin_val;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_val = cin;
`else
  assign cin_val = 1'b0;
`endif

  // Single-bit full-add cell on the current LSBs and the carry flip-flop.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
    carry_bit = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  // Next-state and next-register values for the handshake FSM and datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    out_d   = out;
    carry_d = carry;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = inp1;
          b_d     = inp2;
          c_d     = cin_val;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        s_d   = {sum_bit, s_q[WIDTH-1:1]};
        c_d   = carry_bit;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = {sum_bit, s_q[WIDTH-1:1]};
          carry_d = carry_bit;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      out     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      carry   <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// Reference result is plain integer addition of the operands (plus cin when
// SERIAL_ADDER_CIN_EN is defined); latency and handshake checked by cycle count.
module tb_serial_adder;

  localparam int unsigned W  = 8;
  localparam int unsigned W1 = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] inp1;
  logic [W-1:0] inp2;
  logic         cin_drv;
  logic [W-1:0] out;
  logic         carry;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  logic [W-1:0] prev_out;
  logic         prev_carry;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inp1  (inp1),
    .inp2  (inp2),
`ifdef SERIAL_ADDER_CIN_EN
    .cin   (cin_drv),
`endif
    .out   (out),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit hold_start);
    logic [W:0] exp;
    logic       c_eff;
    int         lat;
    int         busy_n;
`ifdef SERIAL_ADDER_CIN_EN
    c_eff = c;
`else
    c_eff = 1'b0;
`endif
    exp     = W1'(a) + W1'(b) + W1'(c_eff);
    inp1    = a;
    inp2    = b;
    cin_drv = c;
    start   = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < int'(W) + 4) begin
      if (busy) busy_n++;
      check("out_hold_run", 32'(out), 32'(prev_out));
      check("carry_hold_run", 32'(carry), 32'(prev_carry));
      inp1    = W'($urandom);
      inp2    = W'($urandom);
      cin_drv = ~cin_drv;
      if (hold_start && lat >= int'(W) - 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_n), 32'(W));
    check("done_high", 32'(done), 32'(1));
    check("busy_in_done", 32'(busy), 32'(0));
    check("sum", 32'(out), 32'(exp[W-1:0]));
    check("carry", 32'(carry), 32'(exp[W]));
    prev_out   = exp[W-1:0];
    prev_carry = exp[W];
  endtask

  // One idle cycle after a result: done must have been a single pulse.
  task automatic idle_check();
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
    check("out_hold_idle", 32'(out), 32'(prev_out));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_out   = '0;
    prev_carry = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    inp1       = '0;
    inp2       = '0;
    cin_drv    = 1'b0;

    // Reset and quiet idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_out", 32'(out), 32'(0));
      check("rst_carry", 32'(carry), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
    end

    // Directed values and boundaries.
    run_op(8'h2D, 8'h17, 1'b0, 1'b0); idle_check();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0); idle_check();
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0); idle_check();
    run_op(8'h00, 8'h00, 1'b0, 1'b0); idle_check();

    // start held during RUN with operands changing.
    run_op(8'h3C, 8'h55, 1'b0, 1'b1); idle_check();

    // Back-to-back: start in the DONE cycle.
    run_op(8'h12, 8'h34, 1'b0, 1'b0);
    run_op(8'hAB, 8'hCD, 1'b0, 1'b0);
    idle_check();

    // Reset in the middle of an operation.
    inp1  = 8'hA5;
    inp2  = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out", 32'(out), 32'(0));
    check("abort_carry", 32'(carry), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    rst_n      = 1'b1;
    prev_out   = '0;
    prev_carry = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'(0));
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0); idle_check();

`ifdef SERIAL_ADDER_CIN_EN
    run_op(8'h7F, 8'h80, 1'b1, 1'b0); idle_check();
    run_op(8'h7F, 8'h80, 1'b0, 1'b0); idle_check();
`endif

    // Randomised operations, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
